dot_sgn_seq_ctrl: RTL and testbench



---
 rtl/dot_sgn_pkg.sv | 20 ++
 rtl/dot_pair_sgn.sv | 19 +
 rtl/dot_sgn_seq_ctrl.sv | 88 ++++++++
 tb/tb_dot_sgn_seq_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/dot_sgn_pkg.sv
// Shared types and width helpers for the signed dot-product sequencer.
package dot_sgn_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Exact accumulator width: one beat term plus growth for MAX_PAIRS additions.
  function automatic int accw(input int bw, input int max_pairs);
    return 2*bw + 1 + $clog2(max_pairs);
  endfunction

  function automatic int lenw(input int max_pairs);
    return $clog2(max_pairs + 1);
  endfunction

endpackage

// File: rtl/dot_pair_sgn.sv
// Combinational signed a*b + c*d, full precision on 2*BW+1 bits.
module dot_pair_sgn #(
  parameter int BW = 8
) (
  input  logic signed [BW-1:0] i_a,
  input  logic signed [BW-1:0] i_b,
  input  logic signed [BW-1:0] i_c,
  input  logic signed [BW-1:0] i_d,
  output logic signed [2*BW:0] o_p
);

  logic signed [2*BW:0] w_ab, w_cd;

  // Operands are sign-extended first; each product fits in 2*BW bits, the sum in 2*BW+1.
  assign w_ab = (2*BW+1)'(i_a) * (2*BW+1)'(i_b);
  assign w_cd = (2*BW+1)'(i_c) * (2*BW+1)'(i_d);
  assign o_p  = w_ab + w_cd;

endmodule

// File: rtl/dot_sgn_seq_ctrl.sv
// Multi-beat signed dot-product reducer: FSM, beat counter, term register and accumulator.
module dot_sgn_seq_ctrl
  import dot_sgn_pkg::*;
#(
  parameter int BW        = 8,
  parameter int MAX_PAIRS = 16,
  parameter int LENW      = lenw(MAX_PAIRS),
  parameter int ACCW      = accw(BW, MAX_PAIRS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [LENW-1:0] cfg_len,
  input  logic            abort,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [BW-1:0]   in_a,
  input  logic [BW-1:0]   in_b,
  input  logic [BW-1:0]   in_c,
  input  logic [BW-1:0]   in_d,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [ACCW-1:0] out_res,
  output logic            busy
);

  state_e                 r_state;
  logic [LENW-1:0]        r_len, r_cnt;
  logic [LENW-1:0]        w_len, w_cnt_nxt;
  logic signed [2*BW:0]   r_pq, w_term;
  logic                   r_pv;
  logic signed [ACCW-1:0] r_acc, w_pq_ext;
  logic                   w_hs;

  dot_pair_sgn #(.BW(BW)) u_pair (
    .i_a (in_a),
    .i_b (in_b),
    .i_c (in_c),
    .i_d (in_d),
    .o_p (w_term)
  );

  assign w_len     = (cfg_len > LENW'(MAX_PAIRS)) ? LENW'(MAX_PAIRS) : cfg_len;
  assign w_cnt_nxt = r_cnt + LENW'(1);
  assign w_pq_ext  = {{(ACCW-2*BW-1){r_pq[2*BW]}}, r_pq};
  assign in_ready  = (r_state == LOAD) && !abort;
  assign w_hs      = in_valid && in_ready;
  assign out_valid = (r_state == DONE);
  // Result is only exposed in DONE so partial sums never leak out.
  assign out_res   = out_valid ? r_acc : '0;
  assign busy      = (r_state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_len   <= '0;
      r_cnt   <= '0;
      r_pq    <= '0;
      r_pv    <= 1'b0;
      r_acc   <= '0;
    end else if (abort) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_pv    <= 1'b0;
      r_acc   <= '0;
    end else begin
      r_pv <= w_hs;
      if (w_hs) r_pq <= w_term;
      if (r_pv) r_acc <= r_acc + w_pq_ext;
      unique case (r_state)
        IDLE: if (start) begin
          r_len   <= w_len;
          r_cnt   <= '0;
          r_acc   <= '0;
          r_state <= (w_len == '0) ? DRAIN : LOAD;
        end
        LOAD: if (w_hs) begin
          r_cnt <= w_cnt_nxt;
          if (w_cnt_nxt == r_len) r_state <= DRAIN;
        end
        DRAIN:   r_state <= DONE;
        DONE:    if (out_ready) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dot_sgn_seq_ctrl.sv
// Directed bench for dot_sgn_seq_ctrl with hand-computed expected sums.
module tb_dot_sgn_seq_ctrl;

  localparam int BW   = 8;
  localparam int MP   = 16;
  localparam int LENW = 5;
  localparam int ACCW = 21;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [LENW-1:0] cfg_len;
  logic            abort;
  logic            in_valid;
  logic            in_ready;
  logic [BW-1:0]   in_a, in_b, in_c, in_d;
  logic            out_valid;
  logic            out_ready;
  logic [ACCW-1:0] out_res;
  logic            busy;

  int n_vec = 0;
  int n_err = 0;
  int hs;

  dot_sgn_seq_ctrl #(.BW(BW), .MAX_PAIRS(MP)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_d(in_d),
    .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint res();
    return longint'($signed(out_res));
  endfunction

  task automatic beat(input int a, input int b, input int c, input int d);
    in_a = a[BW-1:0];
    in_b = b[BW-1:0];
    in_c = c[BW-1:0];
    in_d = d[BW-1:0];
  endtask

  task automatic go(input int len);
    cfg_len = len[LENW-1:0];
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  task automatic drain_out();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; cfg_len = '0; abort = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0;
    beat(0, 0, 0, 0);
    tick(); tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_res", res(), 0);
    rst = 1'b0;
    tick();

    // Single beat: 3*4 + (-2)*5 = 2, out_valid two edges after the handshake.
    go(1);
    chk("single_busy", busy, 1);
    chk("single_in_ready", in_ready, 1);
    beat(3, 4, -2, 5);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("single_no_ready_after", in_ready, 0);
    chk("single_not_yet_valid", out_valid, 0);
    tick();
    chk("single_valid", out_valid, 1);
    chk("single_res", res(), 2);
    drain_out();
    chk("single_idle", busy, 0);
    chk("single_valid_clr", out_valid, 0);

    // Extreme positive: 16 * 2 * 16384 = 524288.
    go(16);
    beat(-128, -128, -128, -128);
    in_valid = 1'b1;
    hs = 0;
    for (int i = 0; i < 22; i++) begin
      if (in_valid && in_ready) hs++;
      tick();
    end
    chk("pos_hs", hs, 16);
    chk("pos_ready_low", in_ready, 0);
    in_valid = 1'b0;
    chk("pos_valid", out_valid, 1);
    chk("pos_res", res(), 524288);
    drain_out();

    // Extreme negative with gaps: 16 * 2 * (-16256) = -520192.
    go(16);
    beat(-128, 127, -128, 127);
    hs = 0;
    for (int i = 0; i < 40; i++) begin
      in_valid = (i % 2) == 0;
      #0;
      if (in_valid && in_ready) hs++;
      tick();
    end
    in_valid = 1'b0;
    chk("neg_hs", hs, 16);
    chk("neg_valid", out_valid, 1);
    chk("neg_res", res(), -520192);
    drain_out();

    // len=0: DRAIN after start edge, DONE after the next.
    go(0);
    chk("len0_in_ready", in_ready, 0);
    chk("len0_not_yet", out_valid, 0);
    tick();
    chk("len0_valid", out_valid, 1);
    chk("len0_res", res(), 0);
    drain_out();

    // cfg_len=20 clamps to 16 unit-term beats.
    go(20);
    beat(1, 1, 0, 0);
    in_valid = 1'b1;
    hs = 0;
    for (int i = 0; i < 22; i++) begin
      if (in_valid && in_ready) hs++;
      tick();
    end
    in_valid = 1'b0;
    chk("clamp_hs", hs, 16);
    chk("clamp_res", res(), 16);

    // Backpressure: result holds, start is ignored, including in the handshake cycle.
    for (int i = 0; i < 5; i++) begin
      start = 1'b1; cfg_len = 5'd1;
      tick();
      chk("bp_valid", out_valid, 1);
      chk("bp_res", res(), 16);
      chk("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    tick();
    start = 1'b0; out_ready = 1'b0;
    chk("bp_idle", busy, 0);
    chk("bp_valid_clr", out_valid, 0);

    // Abort after 2 of 4 beats, then a fresh vector returns exactly 1.
    go(4);
    beat(5, 5, 5, 5);
    in_valid = 1'b1;
    tick(); tick();
    abort = 1'b1;
    #0;
    chk("abort_ready_forced", in_ready, 0);
    tick();
    abort = 1'b0; in_valid = 1'b0;
    chk("abort_idle", busy, 0);
    chk("abort_in_ready", in_ready, 0);
    go(1);
    beat(1, 1, 0, 0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    chk("post_abort_valid", out_valid, 1);
    chk("post_abort_res", res(), 1);
    drain_out();

    // Asynchronous reset in the middle of LOAD.
    go(4);
    beat(7, 7, 7, 7);
    in_valid = 1'b1;
    tick();
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_in_ready", in_ready, 0);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_res", res(), 0);
    in_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick(); tick();
    chk("arst_stays_idle", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
